// File: rtl/wash_cycle_sequencer.sv
// Wash/rinse/dry run-time scheduler.
// Steps the washer through FILL/AGITATE/DRAIN/SPIN phases per enabled stage,
// counting down one-second ticks, then beeps in DONE before returning to IDLE.
module wash_cycle_sequencer #(
  parameter int unsigned FILL_UNIT = 2,
  parameter int unsigned WASH_SEC  = 6,
  parameter int unsigned RINSE_SEC = 3,
  parameter int unsigned DRAIN_SEC = 2,
  parameter int unsigned SPIN_SEC  = 4,
  parameter int unsigned BEEP_SEC  = 3
) (
  input  logic       clk,
  input  logic       resetBtn,
  input  logic       tick,
  input  logic       start,
  input  logic       doorOpen,
  input  logic [2:0] mode,
  input  logic [1:0] rinseCount,
  input  logic [2:0] waterLevel,
  output logic [2:0] phase,
  output logic [1:0] stage,
  output logic       running,
  output logic       paused,
  output logic [7:0] remaining,
  output logic       inValve,
  output logic       drainPump,
  output logic       motorWash,
  output logic       motorSpin,
  output logic       beep,
  output logic       error
);

  localparam logic [2:0] PH_IDLE = 3'd0;
  localparam logic [2:0] PH_FILL = 3'd1;
  localparam logic [2:0] PH_AGIT = 3'd2;
  localparam logic [2:0] PH_DRAIN = 3'd3;
  localparam logic [2:0] PH_SPIN = 3'd4;
  localparam logic [2:0] PH_DONE = 3'd5;

  localparam logic [7:0] FILL_U  = 8'(FILL_UNIT);
  localparam logic [7:0] WASH_T  = 8'(WASH_SEC);
  localparam logic [7:0] RINSE_T = 8'(RINSE_SEC);
  localparam logic [7:0] DRAIN_T = 8'(DRAIN_SEC);
  localparam logic [7:0] SPIN_T  = 8'(SPIN_SEC);
  localparam logic [7:0] BEEP_T  = 8'(BEEP_SEC);

  typedef struct packed {
    logic [2:0] ph;
    logic [1:0] st;
    logic [7:0] rem;
  } entry_t;

  // Registered state
  logic [2:0] phaseQ, phaseD;
  logic [1:0] stageQ, stageD;
  logic       pausedQ, pausedD;
  logic [7:0] remQ, remD;
  logic [2:0] modeQ, modeD;
  logic [1:0] rinseQ, rinseD;
  logic [2:0] levelQ, levelD;
  logic [1:0] rinseIdxQ, rinseIdxD;
  logic       errD;
  logic       inValveD, drainPumpD, motorWashD, motorSpinD, beepD;

  // Derived helpers
  logic [2:0] levelSel, levelEff;
  logic [1:0] rinseEff;
  logic [7:0] fillLen;
  logic       runQ, qTick;
  entry_t     ent;

  // First phase of the first enabled stage at or after fromStage; DONE if none
  function automatic entry_t firstFrom(input logic [1:0] fromStage,
                                       input logic [2:0] m,
                                       input logic [7:0] fLen,
                                       input logic [1:0] curStage);
    entry_t e;
    e.ph  = PH_DONE;
    e.st  = curStage;
    e.rem = BEEP_T;
    if (fromStage == 2'd0 && m[2]) begin
      e.ph = PH_FILL; e.st = 2'd0; e.rem = fLen;
    end else if (fromStage <= 2'd1 && m[1]) begin
      e.ph = PH_FILL; e.st = 2'd1; e.rem = fLen;
    end else if (m[0]) begin
      e.ph = PH_SPIN; e.st = 2'd2; e.rem = SPIN_T;
    end
    return e;
  endfunction

  // Config comes straight from the inputs while idle, from the latch otherwise
  assign levelSel = (phaseQ == PH_IDLE) ? waterLevel : levelQ;
  assign levelEff = (levelSel == 3'd0) ? 3'd1 : levelSel;
  assign rinseEff = (rinseQ == 2'd0) ? 2'd1 : rinseQ;
  assign fillLen  = 8'(levelEff) * FILL_U;
  assign runQ     = (phaseQ != PH_IDLE) && (phaseQ != PH_DONE);
  // Tick counts only when unpaused before the edge; an open door drops it
  assign qTick    = tick && !pausedQ && (runQ || phaseQ == PH_DONE) &&
                    !(runQ && doorOpen);

  // State register (synchronous reset)
  always_ff @(posedge clk) begin
    if (resetBtn) begin
      phaseQ    <= PH_IDLE;
      stageQ    <= 2'd0;
      pausedQ   <= 1'b0;
      remQ      <= 8'd0;
      modeQ     <= 3'd0;
      rinseQ    <= 2'd0;
      levelQ    <= 3'd0;
      rinseIdxQ <= 2'd0;
      error     <= 1'b0;
      inValve   <= 1'b0;
      drainPump <= 1'b0;
      motorWash <= 1'b0;
      motorSpin <= 1'b0;
      beep      <= 1'b0;
    end else begin
      phaseQ    <= phaseD;
      stageQ    <= stageD;
      pausedQ   <= pausedD;
      remQ      <= remD;
      modeQ     <= modeD;
      rinseQ    <= rinseD;
      levelQ    <= levelD;
      rinseIdxQ <= rinseIdxD;
      error     <= errD;
      inValve   <= inValveD;
      drainPump <= drainPumpD;
      motorWash <= motorWashD;
      motorSpin <= motorSpinD;
      beep      <= beepD;
    end
  end

  // Next-state: start handling, pause control, countdown and phase advance
  always_comb begin
    phaseD    = phaseQ;
    stageD    = stageQ;
    pausedD   = pausedQ;
    remD      = remQ;
    modeD     = modeQ;
    rinseD    = rinseQ;
    levelD    = levelQ;
    rinseIdxD = rinseIdxQ;
    errD      = 1'b0;
    ent       = '0;
    case (phaseQ)
      PH_IDLE: begin
        if (start && !doorOpen) begin
          if (mode == 3'd0) begin
            errD = 1'b1;
          end else begin
            modeD     = mode;
            rinseD    = rinseCount;
            levelD    = waterLevel;
            rinseIdxD = 2'd0;
            pausedD   = 1'b0;
            ent       = firstFrom(2'd0, mode, fillLen, stageQ);
            phaseD    = ent.ph;
            stageD    = ent.st;
            remD      = ent.rem;
          end
        end
      end
      PH_DONE: begin
        if (qTick) begin
          if (remQ == 8'd1) begin
            phaseD = PH_IDLE;
            remD   = 8'd0;
          end else begin
            remD = remQ - 8'd1;
          end
        end
      end
      default: begin
        if (doorOpen) pausedD = 1'b1;
        else if (start) pausedD = !pausedQ;
        if (qTick) begin
          if (remQ != 8'd1) begin
            remD = remQ - 8'd1;
          end else begin
            case (phaseQ)
              PH_FILL: begin
                phaseD = PH_AGIT;
                remD   = (stageQ == 2'd0) ? WASH_T : RINSE_T;
              end
              PH_AGIT: begin
                phaseD = PH_DRAIN;
                remD   = DRAIN_T;
              end
              PH_DRAIN: begin
                if (stageQ == 2'd1 &&
                    ({1'b0, rinseIdxQ} + 3'd1) < {1'b0, rinseEff}) begin
                  rinseIdxD = rinseIdxQ + 2'd1;
                  phaseD    = PH_FILL;
                  remD      = fillLen;
                end else begin
                  ent    = firstFrom((stageQ == 2'd0) ? 2'd1 : 2'd2,
                                     modeQ, fillLen, stageQ);
                  phaseD = ent.ph;
                  stageD = ent.st;
                  remD   = ent.rem;
                end
              end
              default: begin
                phaseD = PH_DONE;
                remD   = BEEP_T;
              end
            endcase
          end
        end
      end
    endcase
  end

  // Outputs: actuators follow the next phase so they register alongside it
  always_comb begin
    inValveD   = (phaseD == PH_FILL) && !pausedD;
    motorWashD = (phaseD == PH_AGIT) && !pausedD;
    drainPumpD = ((phaseD == PH_DRAIN) || (phaseD == PH_SPIN)) && !pausedD;
    motorSpinD = (phaseD == PH_SPIN) && !pausedD;
    beepD      = (phaseD == PH_DONE);
    phase      = phaseQ;
    stage      = stageQ;
    paused     = pausedQ;
    remaining  = remQ;
    running    = runQ;
  end

endmodule

// File: tb/tb_wash_cycle_sequencer.sv
// Scoreboard bench: stimulus queues expected output snapshots; a monitor
// pops one each time the DUT's visible outputs change.
module tb_wash_cycle_sequencer;

  logic       clk = 1'b0;
  logic       resetBtn, tick, start, doorOpen;
  logic [2:0] mode, waterLevel;
  logic [1:0] rinseCount;
  logic [2:0] phase;
  logic [1:0] stage;
  logic       running, paused, inValve, drainPump, motorWash, motorSpin, beep, error;
  logic [7:0] remaining;

  typedef struct packed {
    logic [2:0] ph;
    logic [1:0] st;
    logic       run;
    logic       pau;
    logic [7:0] rem;
    logic       vlv, drn, mw, ms, bp, er;
  } snap_t;

  snap_t expQ[$];
  int    compared = 0;
  int    mismatched = 0;
  logic  monOn = 1'b0;

  wash_cycle_sequencer dut (
    .clk(clk), .resetBtn(resetBtn), .tick(tick), .start(start),
    .doorOpen(doorOpen), .mode(mode), .rinseCount(rinseCount),
    .waterLevel(waterLevel), .phase(phase), .stage(stage),
    .running(running), .paused(paused), .remaining(remaining),
    .inValve(inValve), .drainPump(drainPump), .motorWash(motorWash),
    .motorSpin(motorSpin), .beep(beep), .error(error)
  );

  always #5 clk = ~clk;

  function automatic snap_t mk(input logic [2:0] ph, input logic [1:0] st,
                               input logic pau, input logic [7:0] rem,
                               input logic er);
    snap_t s;
    logic  act;
    s.ph  = ph;
    s.st  = st;
    s.run = (ph >= 3'd1) && (ph <= 3'd4);
    s.pau = pau;
    s.rem = rem;
    act   = s.run && !pau;
    s.vlv = act && ph == 3'd1;
    s.mw  = act && ph == 3'd2;
    s.drn = act && (ph == 3'd3 || ph == 3'd4);
    s.ms  = act && ph == 3'd4;
    s.bp  = (ph == 3'd5);
    s.er  = er;
    return s;
  endfunction

  task automatic pushPh(input logic [2:0] ph, input logic [1:0] st, input int dur);
    for (int r = dur; r >= 1; r--) expQ.push_back(mk(ph, st, 1'b0, 8'(r), 1'b0));
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulseStart();
    start = 1'b1; step(1); start = 1'b0;
  endtask

  task automatic tickN(input int n);
    repeat (n) begin
      tick = 1'b1; step(1); tick = 1'b0; step(3);
    end
  endtask

  // Monitor: every change of the output snapshot is one DUT response
  initial begin : monitor
    snap_t cur, prev, e;
    prev = '1;
    wait (monOn);
    forever begin
      @(negedge clk);
      cur = {phase, stage, running, paused, remaining,
             inValve, drainPump, motorWash, motorSpin, beep, error};
      if (cur !== prev) begin
        prev = cur;
        compared++;
        if (expQ.size() == 0) begin
          mismatched++;
          $display("FAIL unexpected_change t=%0t: got %h, required no change", $time, cur);
        end else begin
          e = expQ.pop_front();
          if (cur !== e) begin
            mismatched++;
            $display("FAIL snapshot#%0d t=%0t: got ph=%0d st=%0d pau=%0d rem=%0d raw=%h, required ph=%0d st=%0d pau=%0d rem=%0d raw=%h",
                     compared, $time, cur.ph, cur.st, cur.pau, cur.rem, cur,
                     e.ph, e.st, e.pau, e.rem, e);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    resetBtn = 1'b1; tick = 1'b0; start = 1'b0; doorOpen = 1'b0;
    mode = 3'd0; rinseCount = 2'd0; waterLevel = 3'd0;
    step(1);
    expQ.push_back(mk(3'd0, 2'd0, 1'b0, 8'd0, 1'b0));
    monOn = 1'b1;
    step(1);
    resetBtn = 1'b0;
    step(2);

    // Full program: wash + rinse + dry
    mode = 3'b111; waterLevel = 3'd2; rinseCount = 2'd1;
    pushPh(3'd1, 2'd0, 4); pushPh(3'd2, 2'd0, 6); pushPh(3'd3, 2'd0, 2);
    pushPh(3'd1, 2'd1, 4); pushPh(3'd2, 2'd1, 3); pushPh(3'd3, 2'd1, 2);
    pushPh(3'd4, 2'd2, 4); pushPh(3'd5, 2'd2, 3);
    expQ.push_back(mk(3'd0, 2'd2, 1'b0, 8'd0, 1'b0));
    pulseStart(); step(2);
    mode = 3'b000; waterLevel = 3'd7; rinseCount = 2'd3; // ignored mid-run
    tickN(28); step(4);

    // Rinse only, two repetitions, level 0 treated as 1
    mode = 3'b010; rinseCount = 2'd2; waterLevel = 3'd0;
    pushPh(3'd1, 2'd1, 2); pushPh(3'd2, 2'd1, 3); pushPh(3'd3, 2'd1, 2);
    pushPh(3'd1, 2'd1, 2); pushPh(3'd2, 2'd1, 3); pushPh(3'd3, 2'd1, 2);
    pushPh(3'd5, 2'd1, 3);
    expQ.push_back(mk(3'd0, 2'd1, 1'b0, 8'd0, 1'b0));
    pulseStart(); tickN(17); step(4);

    // Rejected start (mode 0) then door-open start (ignored, no error)
    mode = 3'b000;
    expQ.push_back(mk(3'd0, 2'd1, 1'b0, 8'd0, 1'b1));
    expQ.push_back(mk(3'd0, 2'd1, 1'b0, 8'd0, 1'b0));
    pulseStart(); step(3);
    mode = 3'b111; doorOpen = 1'b1;
    pulseStart(); step(3);
    doorOpen = 1'b0; step(2);

    // Wash only: door pause in AGITATE at remaining 5
    mode = 3'b100; waterLevel = 3'd1; rinseCount = 2'd0;
    pushPh(3'd1, 2'd0, 2);
    expQ.push_back(mk(3'd2, 2'd0, 1'b0, 8'd6, 1'b0));
    expQ.push_back(mk(3'd2, 2'd0, 1'b0, 8'd5, 1'b0));
    expQ.push_back(mk(3'd2, 2'd0, 1'b1, 8'd5, 1'b0));
    expQ.push_back(mk(3'd2, 2'd0, 1'b0, 8'd5, 1'b0));
    pulseStart(); tickN(3);
    doorOpen = 1'b1; tick = 1'b1; step(1); tick = 1'b0; step(3);
    tickN(2);
    doorOpen = 1'b0; step(3);
    tickN(1);
    pulseStart(); step(3);

    // start+tick: pause at 3->2, then resume with tick dropped
    expQ.push_back(mk(3'd2, 2'd0, 1'b0, 8'd4, 1'b0));
    expQ.push_back(mk(3'd2, 2'd0, 1'b0, 8'd3, 1'b0));
    expQ.push_back(mk(3'd2, 2'd0, 1'b1, 8'd2, 1'b0));
    expQ.push_back(mk(3'd2, 2'd0, 1'b0, 8'd2, 1'b0));
    expQ.push_back(mk(3'd2, 2'd0, 1'b0, 8'd1, 1'b0));
    pushPh(3'd3, 2'd0, 2); pushPh(3'd5, 2'd0, 3);
    expQ.push_back(mk(3'd0, 2'd0, 1'b0, 8'd0, 1'b0));
    tickN(2);
    start = 1'b1; tick = 1'b1; step(1); start = 1'b0; tick = 1'b0; step(3);
    tickN(1);
    start = 1'b1; tick = 1'b1; step(1); start = 1'b0; tick = 1'b0; step(3);
    tickN(7); step(4);

    // Reset during SPIN, then dry-only run
    mode = 3'b001;
    expQ.push_back(mk(3'd4, 2'd2, 1'b0, 8'd4, 1'b0));
    expQ.push_back(mk(3'd4, 2'd2, 1'b0, 8'd3, 1'b0));
    expQ.push_back(mk(3'd0, 2'd0, 1'b0, 8'd0, 1'b0));
    pulseStart(); tickN(1);
    resetBtn = 1'b1; step(1); resetBtn = 1'b0; step(2);
    pushPh(3'd4, 2'd2, 4); pushPh(3'd5, 2'd2, 3);
    expQ.push_back(mk(3'd0, 2'd2, 1'b0, 8'd0, 1'b0));
    pulseStart(); tickN(7); step(4);

    compared++;
    if (expQ.size() != 0) begin
      mismatched++;
      $display("FAIL queue_drain: got %0d pending responses, required 0", expQ.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/wash_cycle_sequencer.md
# wash_cycle_sequencer

Run-time scheduler for the washer's wash/rinse/dry program. It latches the user's program selection on start. It then steps the water valve, drain pump and motor through fill, agitate, drain and spin phases, using one-second ticks from the clock divider. It sits between the state controller (start/door events) and the view layer, which displays phase, stage and remaining seconds.

## Interface
Parameters:
- FILL_UNIT, 2: fill seconds per water-level unit (FILL_UNIT*7 ≤ 255)
- WASH_SEC, 6: agitate seconds, wash stage
- RINSE_SEC, 3: agitate seconds, each rinse
- DRAIN_SEC, 2: drain seconds
- SPIN_SEC, 4: dry spin seconds
- BEEP_SEC, 3: completion beep seconds (all durations 1..255)

Ports:
- clk  in  1  system clock. One clock; reset is synchronous and active-high.
- resetBtn  in  1  synchronous, active-high reset
- tick  in  1  one-cycle pulse per second
- start  in  1  one-cycle pulse; start or pause toggle
- doorOpen  in  1  door level, 1 = open
- mode  in  3  [2] wash, [1] rinse, [0] dry enables
- rinseCount  in  2  rinse repetitions; 0 treated as 1
- waterLevel  in  3  fill level; 0 treated as 1
- phase  out  3  0 IDLE, 1 FILL, 2 AGITATE, 3 DRAIN, 4 SPIN, 5 DONE
- stage  out  2  0 wash, 1 rinse, 2 dry
- running  out  1  phase ∉ {IDLE, DONE}
- paused  out  1  run suspended
- remaining  out  8  seconds left in current phase
- inValve, drainPump, motorWash, motorSpin  out  1 each  actuators
- beep  out  1  high throughout DONE
- error  out  1  one-cycle pulse on rejected start

## Operation
- IDLE, start, doorOpen=0, mode≠0:
  - latch mode, rinseCount and waterLevel.
  - Enter the first enabled stage at the next edge.
  - Config inputs are ignored until the sequencer returns to IDLE.
- IDLE, start, mode=0: stay in IDLE; error=1 for one cycle.
- IDLE, start, doorOpen=1: ignored; no error pulse.
- Stage sequences:
  - wash: FILL → AGITATE(WASH_SEC) → DRAIN.
  - rinse: FILL → AGITATE(RINSE_SEC) → DRAIN, repeated rinseCount times. stage stays 1 throughout.
  - dry: SPIN(SPIN_SEC).
  - Disabled stages are skipped.
  - After the last enabled stage: DONE(BEEP_SEC) → IDLE.
- Phase durations:
  - FILL lasts waterLevel*FILL_UNIT.
  - DRAIN lasts DRAIN_SEC.
  - All arithmetic is 8-bit unsigned and cannot overflow under the parameter limits.
- Actuators (only while running and not paused; all 0 otherwise):
  - FILL: inValve.
  - AGITATE: motorWash.
  - DRAIN: drainPump.
  - SPIN: motorSpin and drainPump.
- Pause:
  - start while running and doorOpen=0 toggles paused.
  - doorOpen=1 while running forces paused=1. Closing the door does not clear it; a start is required.
  - start is ignored in DONE.
- stage during IDLE and DONE holds its last value; reset value is 0.

## Timing
- Reset values: phase=0, stage=0, paused=0, remaining=0, all actuators=0, beep=0, error=0.
- Start accept:
  - Edge N samples start.
  - After edge N: phase = first phase, remaining = its duration, actuator on.
- Countdown:
  - remaining decrements at each edge where tick=1, running or DONE, and paused=0.
  - On a tick with remaining=1, the next phase and its duration load at that same edge, so remaining never shows 0 outside IDLE.
  - DONE expiry → IDLE with remaining=0.
- Pause/tick interaction:
  - A tick is qualified by paused as registered before the edge.
  - start and tick in the same cycle: the tick counts if the sequencer was unpaused, and the pause toggles at the same edge.
- Door and tick in the same cycle: pause wins, and the tick is dropped.
- Actuators are registered with phase. They drop at the same edge that paused rises.
- Reset mid-run: the next edge returns to IDLE with all outputs at reset values, regardless of phase.

## Test plan
- mode=111, waterLevel=2, rinseCount=1, ticks every 4 cycles:
  - phases FILL4, AGITATE6, DRAIN2, FILL4, AGITATE3, DRAIN2, SPIN4, DONE3 (28 ticks total), then IDLE.
  - beep=1 only during DONE.
- mode=010, rinseCount=2, waterLevel=0:
  - FILL2, AGITATE3, DRAIN2, FILL2, AGITATE3, DRAIN2, DONE3.
  - stage=1 throughout.
- start with mode=000: error pulses for exactly 1 cycle, phase stays 0. start with doorOpen=1: no change, no error.
- In AGITATE with remaining=5:
  - raise doorOpen: paused=1, motorWash=0, ticks ignored.
  - close door: still paused.
  - start: resumes at remaining=5.
- start and tick in the same cycle while unpaused with remaining=3: remaining=2 and paused=1 after the edge. Later start+tick with remaining=2: resume, remaining stays 2.
- resetBtn asserted during SPIN: after one edge all outputs are at reset values. A subsequent start with mode=001 gives SPIN4 then DONE3.
